// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding a bit-timed serialiser, LSB first.
// Default frame is 8N1. Defining UART_TX_PARITY_EN adds an even-parity bit (8E1).
module uart_tx_buffered #(
    parameter int unsigned CLK_PER_BIT = 868,
    parameter int unsigned DEPTH_LOG2  = 4
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [7:0]            data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  UART_TX
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam int unsigned CYC_W = $clog2(CLK_PER_BIT);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLK_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [2:0]       state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       mem_q [DEPTH];
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             push_c;
    logic             pop_c;
    logic [7:0]       head_c;
    logic             cyc_end_c;

    assign ready_out  = (count_q != CNT_W'(DEPTH));
    assign busy       = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_count = count_q;
    assign UART_TX    = tx_q;

    assign push_c    = valid_in & ready_out;
    assign head_c    = mem_q[rd_ptr_q];
    assign cyc_end_c = (cyc_q == CYC_LAST);

    // Serialiser next state; line level is derived from the next state so UART_TX is registered
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_c   = 1'b0;
        tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop_c   = 1'b1;
                    shift_d = head_c;
                    cyc_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cyc_end_c) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            S_DATA: begin
                if (cyc_end_c) begin
                    cyc_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (cyc_end_c) begin
                    cyc_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (cyc_end_c) begin
                    cyc_d = '0;
                    if (count_q != '0) begin
                        // Back-to-back frames: go straight to START without an idle bit
                        pop_c   = 1'b1;
                        shift_d = head_c;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = '0;
            end
        endcase

`ifdef UART_TX_PARITY_EN
        if (pop_c) begin
            par_d = ^head_c;
        end
`endif

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge CLK) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Control and line registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with a byte scoreboard fed by a line decoder.
module tb_uart_tx_buffered;

    localparam int BIT = 8;
    localparam int DL2 = 2;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * BIT;
`else
    localparam int FRAME = 10 * BIT;
`endif

    logic           CLK = 1'b0;
    logic           reset;
    logic [7:0]     data_in;
    logic           valid_in;
    logic           ready_out;
    logic           busy;
    logic [DL2:0]   fifo_count;
    logic           UART_TX;

    int             n_pass = 0;
    int             n_total = 0;
    int             cycnt = 0;
    int             rst_gen = 0;
    logic [7:0]     exp_q [$];
    int             starts_q [$];

    uart_tx_buffered #(.CLK_PER_BIT(BIT), .DEPTH_LOG2(DL2)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .busy       (busy),
        .fifo_count (fifo_count),
        .UART_TX    (UART_TX)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cycnt <= cycnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one push on the next rising edge; acc reports whether it was accepted
    task automatic push(input logic [7:0] b, output logic acc);
        @(negedge CLK);
        data_in  = b;
        valid_in = 1'b1;
        acc      = ready_out;
        if (acc) exp_q.push_back(b);
        @(posedge CLK);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        chk(tag, busy, 0);
    endtask

    // Line decoder: samples mid-bit, checks framing and pops the scoreboard
    logic [7:0] m_b;
    logic [7:0] m_e;
    logic       m_st, m_sp, m_pb;
    int         m_g;
    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (UART_TX === 1'b0) begin
                m_g = rst_gen;
                starts_q.push_back(cycnt);
                repeat (BIT / 2) @(negedge CLK);
                m_st = UART_TX;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge CLK);
                    m_b[i] = UART_TX;
                end
                m_pb = 1'b0;
`ifdef UART_TX_PARITY_EN
                repeat (BIT) @(negedge CLK);
                m_pb = UART_TX;
`endif
                repeat (BIT) @(negedge CLK);
                m_sp = UART_TX;
                repeat (BIT / 2 - 1) @(negedge CLK);
                if (m_g == rst_gen) begin
                    chk("start_bit", m_st, 0);
                    chk("stop_bit", m_sp, 1);
                    n_total++;
                    assert (exp_q.size() > 0) n_pass++;
                    else $error("FAIL sb_unexpected: observed byte %0h expected none", m_b);
                    if (exp_q.size() > 0) begin
                        m_e = exp_q.pop_front();
                        chk("rx_byte", m_b, m_e);
`ifdef UART_TX_PARITY_EN
                        chk("parity_bit", m_pb, ^m_e);
`endif
                    end
                end else begin
                    void'(starts_q.pop_back());
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000 ns");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic acc;
        int   t, n0;
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;

        // Reset held three cycles
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_tx", UART_TX, 1);
        chk("rst_ready", ready_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        reset = 1'b0;

        // Single byte: latency, frame length, busy fall
        push(8'hA5, acc);
        t = cycnt;
        chk("t2_acc", acc, 1);
        @(negedge CLK);
        chk("t2_count1", fifo_count, 1);
        chk("t2_tx_idle", UART_TX, 1);
        @(posedge CLK);
        @(negedge CLK);
        chk("t2_tx_start", UART_TX, 0);
        chk("t2_count0", fifo_count, 0);
        chk("t2_busy", busy, 1);
        repeat (FRAME - 1) @(posedge CLK);
        @(negedge CLK);
        chk("t2_busy_stop", busy, 1);
        chk("t2_tx_stop", UART_TX, 1);
        @(posedge CLK);
        @(negedge CLK);
        chk("t2_busy_fall", busy, 0);
        chk("t2_start_cyc", starts_q[starts_q.size() - 1], t + 1);
        chk("t2_sb_empty", exp_q.size(), 0);

        // Burst fills FIFO; frames must be contiguous
        n0 = starts_q.size();
        push(8'h00, acc); chk("t3_acc0", acc, 1);
        push(8'hFF, acc); chk("t3_acc1", acc, 1);
        push(8'h55, acc); chk("t3_acc2", acc, 1);
        push(8'h3C, acc); chk("t3_acc3", acc, 1);
        push(8'h81, acc); chk("t3_acc4", acc, 1);
        @(negedge CLK);
        chk("t3_ready_full", ready_out, 0);
        push(8'hEE, acc); chk("t3_acc_blocked", acc, 0);
        @(negedge CLK);
        chk("t3_count_full", fifo_count, 4);
        wait_idle(6 * FRAME, "t3_idle");
        chk("t3_frames", starts_q.size(), n0 + 5);
        for (int i = 1; i < 5; i++) begin
            chk("t3_gap", starts_q[n0 + i] - starts_q[n0 + i - 1], FRAME);
        end
        chk("t3_sb_empty", exp_q.size(), 0);

        // Push on the same edge as the STOP-end pop
        push(8'h12, acc);
        t = cycnt;
        push(8'h34, acc);
        push(8'h56, acc);
        @(negedge CLK);
        chk("t4_count_pre", fifo_count, 2);
        repeat (FRAME - 3) @(posedge CLK);
        @(negedge CLK);
        chk("t4_count_hold", fifo_count, 2);
        push(8'h78, acc);
        chk("t4_edge", cycnt, t + 1 + FRAME);
        @(negedge CLK);
        chk("t4_count_same", fifo_count, 2);
        chk("t4_tx_restart", UART_TX, 0);
        wait_idle(5 * FRAME, "t4_idle");
        chk("t4_sb_empty", exp_q.size(), 0);

        // Reset mid-frame drops the frame and the buffered byte
        push(8'h5A, acc);
        push(8'h11, acc);
        repeat (29) @(posedge CLK);
        @(negedge CLK);
        chk("t5_tx_bit2", UART_TX, 0);
        chk("t5_count", fifo_count, 1);
        rst_gen++;
        exp_q.delete();
        reset = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        chk("t5_tx", UART_TX, 1);
        chk("t5_count0", fifo_count, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ready", ready_out, 1);
        repeat (FRAME + 16) @(negedge CLK);
        chk("t5_still_idle", busy, 0);
        chk("t5_tx_high", UART_TX, 1);

        // Parity-sensitive bytes, back to back
        n0 = starts_q.size();
        push(8'h07, acc);
        push(8'h03, acc);
        wait_idle(3 * FRAME, "t6_idle");
        chk("t6_frames", starts_q.size(), n0 + 2);
        chk("t6_gap", starts_q[n0 + 1] - starts_q[n0], FRAME);
        chk("t6_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
